// File: rtl/uart_frame_loader_if.sv
// Byte-in / pixel-out bundle for the UART frame loader.
// slave is the loader side, master the surrounding system.
interface uart_frame_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        uart_data;
  logic              uart_done;
  logic              frame_ack;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        pix_data;
  logic              frame_ready;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  uart_data, uart_done, frame_ack,
    output pix_we, pix_addr, pix_data,
    output frame_ready, frame_err, busy
  );

  modport master (
    output uart_data, uart_done, frame_ack,
    input  pix_we, pix_addr, pix_data,
    input  frame_ready, frame_err, busy
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Parses sync + 784 pixel bytes + checksum from the UART stream
// into the pixel RAM and holds frame_ready until acknowledged.
module uart_frame_loader #(
  parameter int         PIX_NUM        = 784,
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] SYNC0          = 8'hAA,
  parameter logic [7:0] SYNC1          = 8'h55,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input logic                sys_clk,
  input logic                sys_rst_n,
  uart_frame_loader_if.slave bus
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_MAX =
    GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX =
    ADDR_W'(PIX_NUM - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, PIXEL, CHECK, READY
  } state_t;

  state_t            state;
  logic              done_d;
  logic [ADDR_W-1:0] pix_cnt;
  logic [7:0]        sum;
  logic [GAP_W-1:0]  gap_cnt;

  logic byte_stb;
  logic active;
  logic timeout;

  assign byte_stb = bus.uart_done & ~done_d;
  assign active   = (state == SYNC) || (state == PIXEL) ||
                    (state == CHECK);
  assign timeout  = active && (gap_cnt == GAP_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      done_d          <= 1'b0;
      pix_cnt         <= '0;
      sum             <= '0;
      gap_cnt         <= '0;
      bus.pix_we      <= 1'b0;
      bus.pix_addr    <= '0;
      bus.pix_data    <= '0;
      bus.frame_ready <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      done_d        <= bus.uart_done;
      bus.pix_we    <= 1'b0;
      bus.frame_err <= 1'b0;
      // A strobe landing on the timeout cycle is dropped.
      if (timeout) begin
        state         <= IDLE;
        gap_cnt       <= '0;
        bus.frame_err <= 1'b1;
        bus.busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            gap_cnt <= '0;
            if (byte_stb && bus.uart_data == SYNC0) begin
              state    <= SYNC;
              bus.busy <= 1'b1;
            end
          end
          SYNC: begin
            if (byte_stb) begin
              gap_cnt <= '0;
              if (bus.uart_data == SYNC1) begin
                state   <= PIXEL;
                pix_cnt <= '0;
                sum     <= '0;
              end else if (bus.uart_data != SYNC0) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          PIXEL: begin
            if (byte_stb) begin
              gap_cnt      <= '0;
              bus.pix_we   <= 1'b1;
              bus.pix_addr <= pix_cnt;
              bus.pix_data <= bus.uart_data;
              sum          <= sum + bus.uart_data;
              pix_cnt      <= pix_cnt + ADDR_W'(1);
              if (pix_cnt == LAST_PIX) state <= CHECK;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          CHECK: begin
            if (byte_stb) begin
              gap_cnt  <= '0;
              bus.busy <= 1'b0;
              if (bus.uart_data == sum) begin
                state           <= READY;
                bus.frame_ready <= 1'b1;
              end else begin
                state         <= IDLE;
                bus.frame_err <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          READY: begin
            gap_cnt <= '0;
            if (bus.frame_ack) begin
              state           <= IDLE;
              bus.frame_ready <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            gap_cnt  <= '0;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: expected pixel writes
// are queued as bytes are sent and matched against pix_we pulses.
module tb_uart_frame_loader;

  localparam int PIX = 784;
  localparam int TO  = 200;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  uart_frame_loader_if #(.ADDR_W(10)) bus ();

  uart_frame_loader #(
    .PIX_NUM(PIX),
    .ADDR_W(10),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int err_cnt = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.frame_err) err_cnt++;
      if (bus.pix_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexp_we", {22'd0, bus.pix_addr}, 32'hFFFF);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {22'd0, bus.pix_addr}, {22'd0, e[17:8]});
          chk("wr_data", {24'd0, bus.pix_data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge sys_clk);
    bus.uart_data = b;
    bus.uart_done = 1'b1;
    repeat (hold) @(negedge sys_clk);
    bus.uart_done = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send_pix(input int a, input logic [7:0] b,
                          input int hold);
    exp_q.push_back({a[9:0], b});
    send(b, hold);
  endtask

  task automatic pixels(input int n, input int hold,
                        output logic [7:0] s);
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      send_pix(i, i[7:0], hold);
      s = s + i[7:0];
    end
  endtask

  task automatic frame(input logic [7:0] delta, input int hold);
    logic [7:0] s;
    send(8'hAA, hold);
    send(8'h55, hold);
    pixels(PIX, hold, s);
    send(s + delta, hold);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic ack();
    @(negedge sys_clk);
    bus.frame_ack = 1'b1;
    @(negedge sys_clk);
    bus.frame_ack = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_we"},  {31'd0, bus.pix_we}, 32'd0);
    chk({tag, "_adr"}, {22'd0, bus.pix_addr}, 32'd0);
    chk({tag, "_dat"}, {24'd0, bus.pix_data}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, bus.frame_ready}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_bsy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int w0, e0;
    logic [7:0] s;
    sys_rst_n     = 1'b0;
    bus.uart_data = 8'h00;
    bus.uart_done = 1'b0;
    bus.frame_ack = 1'b0;
    repeat (3) @(negedge sys_clk);
    outs_zero("rst");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // good frame; checksum of i mod 256 is F8
    w0 = wr_cnt; e0 = err_cnt;
    frame(8'd0, 2);
    chk("good_rdy",  {31'd0, bus.frame_ready}, 32'd1);
    chk("good_wr",   wr_cnt - w0, PIX);
    chk("good_err",  err_cnt - e0, 0);
    chk("good_q",    exp_q.size(), 0);
    ack();
    chk("ack_rdy",   {31'd0, bus.frame_ready}, 32'd0);
    chk("ack_busy",  {31'd0, bus.busy}, 32'd0);

    // bad checksum F7
    w0 = wr_cnt; e0 = err_cnt;
    frame(8'hFF, 2);
    chk("bad_wr",    wr_cnt - w0, PIX);
    chk("bad_err",   err_cnt - e0, 1);
    chk("bad_rdy",   {31'd0, bus.frame_ready}, 32'd0);
    chk("bad_busy",  {31'd0, bus.busy}, 32'd0);

    // resync with held uart_done
    w0 = wr_cnt; e0 = err_cnt;
    send(8'h00, 40);
    send(8'hAA, 40);
    frame(8'd0, 40);
    chk("rsy_rdy",   {31'd0, bus.frame_ready}, 32'd1);
    chk("rsy_wr",    wr_cnt - w0, PIX);
    chk("rsy_err",   err_cnt - e0, 0);
    ack();

    // timeout after 100 pixels
    w0 = wr_cnt; e0 = err_cnt;
    send(8'hAA, 2);
    send(8'h55, 2);
    pixels(100, 2, s);
    chk("to_busy1",  {31'd0, bus.busy}, 32'd1);
    repeat (TO + 5) @(negedge sys_clk);
    chk("to_err",    err_cnt - e0, 1);
    chk("to_busy0",  {31'd0, bus.busy}, 32'd0);
    chk("to_wr",     wr_cnt - w0, 100);
    frame(8'd0, 2);
    chk("to_rdy",    {31'd0, bus.frame_ready}, 32'd1);
    chk("to_q",      exp_q.size(), 0);

    // READY ignores bytes; ack+strobe discards the byte
    w0 = wr_cnt;
    send(8'hAA, 2);
    send(8'h55, 2);
    send(8'h03, 2);
    chk("hold_wr",   wr_cnt - w0, 0);
    chk("hold_rdy",  {31'd0, bus.frame_ready}, 32'd1);
    @(negedge sys_clk);
    bus.uart_data = 8'hAA;
    bus.uart_done = 1'b1;
    bus.frame_ack = 1'b1;
    @(negedge sys_clk);
    bus.frame_ack = 1'b0;
    repeat (2) @(negedge sys_clk);
    bus.uart_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("hack_rdy",  {31'd0, bus.frame_ready}, 32'd0);
    send(8'h55, 2);
    chk("hack_busy", {31'd0, bus.busy}, 32'd0);

    // reset mid-frame
    send(8'hAA, 2);
    send(8'h55, 2);
    pixels(300, 2, s);
    #3 sys_rst_n = 1'b0;
    #1 outs_zero("mrst");
    exp_q.delete();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    w0 = wr_cnt; e0 = err_cnt;
    frame(8'd0, 2);
    chk("mrst_rdy",  {31'd0, bus.frame_ready}, 32'd1);
    chk("mrst_wr",   wr_cnt - w0, PIX);
    chk("mrst_err",  err_cnt - e0, 0);
    chk("mrst_q",    exp_q.size(), 0);
    ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
